// File: rtl/seq_mult.sv
// ---------------------------------------------------------------------------
// seq_mult -- multi-cycle unsigned shift-add multiplier.
//
// Accepts two N-bit unsigned operands on a start pulse (sampled only while
// idle), performs one partial-product step per clock for N clocks, then
// presents the registered 2N-bit product together with a one-cycle done
// strobe. The product register holds its value until the next completed
// operation or a reset, so a downstream register may sample it at any time
// after done.
//
// Handshake: start is a request that is accepted on any rising edge where
// the block is idle; there is no ready output. busy is high for the N RUN
// cycles, done is high for exactly one cycle after them, and the two are
// never high together. start seen while busy or done is ignored.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; abandons any operation
//   start      multiply request, sampled only in IDLE
//   a          multiplicand (N bits), captured on the accepted start
//   b          multiplier (N bits), captured on the accepted start
//   busy       high while iterating (RUN)
//   done       one-cycle pulse, product valid
//   product    registered 2N-bit result of the last completed multiply
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE) for observation
// ---------------------------------------------------------------------------
module seq_mult #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [1:0]     dbg_state
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  // Accumulator: bit 2N is the carry of the upper-half add, bits
  // [2N-1:N] the running partial sum, bits [N-1:0] the unconsumed
  // multiplier bits (LSB first).
  logic [2*N:0]     acc_q,   acc_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [2*N-1:0]   product_q, product_d;

  // One shift-add iteration, computed combinationally from the current
  // accumulator. The add is N+1 bits wide so the carry is never lost.
  logic [N:0]       add_sum;
  logic [2*N:0]     acc_added;
  logic [2*N:0]     acc_shift;

  always_comb begin
    add_sum   = acc_q[2*N:N] + {1'b0, mcand_q};
    acc_added = acc_q[0] ? {add_sum, acc_q[N-1:0]} : acc_q;
    acc_shift = acc_added >> 1;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{(N+1){1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_shift;
        cnt_d = cnt_q + CW'(1);
        // cnt_q counts completed iterations; this edge is the N-th one.
        if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          product_d = acc_shift[2*N-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the state being entered.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_mult -- directed plus randomized checks of seq_mult at N=8 and N=32.
// Expected products come from plain 64-bit multiplication of the operands
// the bench applied, queued at the start edge and popped at done.
// ---------------------------------------------------------------------------
module tb_seq_mult;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic [1:0]  st8;

  logic        start32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;
  logic [1:0]  st32;

  seq_mult #(.N(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .busy      (busy8),
    .done      (done8),
    .product   (prod8),
    .dbg_state (st8)
  );

  seq_mult #(.N(32)) u_dut32 (
    .clk       (clk),
    .reset     (reset),
    .start     (start32),
    .a         (a32),
    .b         (b32),
    .busy      (busy32),
    .done      (done32),
    .product   (prod32),
    .dbg_state (st32)
  );

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_errors;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Observation helpers selecting one DUT (sel=1 -> N=32).
  function automatic logic obs_busy(input bit sel);
    return sel ? busy32 : busy8;
  endfunction
  function automatic logic obs_done(input bit sel);
    return sel ? done32 : done8;
  endfunction
  function automatic logic [63:0] obs_prod(input bit sel);
    return sel ? prod32 : {48'd0, prod8};
  endfunction

  // ---------------- driver tasks ----------------
  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic s, input logic [63:0] av, input logic [63:0] bv);
    if (sel) begin
      start32 = s; a32 = av[31:0]; b32 = bv[31:0];
    end else begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0];
    end
  endtask

  // Launch one multiply and follow it to completion. After the start edge
  // the operand bus is scrambled (or set to next_a/next_b when keep_start
  // holds start high) to prove only the captured copies are used.
  task automatic run_op(input bit sel, input logic [63:0] av, input logic [63:0] bv,
                        input bit keep_start, input logic [63:0] next_a,
                        input logic [63:0] next_b);
    int n;
    int cycles;
    logic [63:0] mask;
    logic [63:0] prev;
    logic [63:0] exp;
    n    = sel ? 32 : 8;
    mask = sel ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_00FF;
    exp_q.push_back((av & mask) * (bv & mask));
    prev = obs_prod(sel);
    drive(sel, 1'b1, av, bv);
    tick();                                   // start edge E0
    if (keep_start) drive(sel, 1'b1, next_a, next_b);
    else drive(sel, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    cycles = 1;
    while (!obs_done(sel) && cycles < n + 8) begin
      check("busy_in_run", {63'd0, obs_busy(sel)}, 64'd1);
      check("product_hold", obs_prod(sel), prev);
      tick();
      cycles++;
    end
    // Edges E0..EN inclusive: done appears N+1 edges after start.
    check("latency", cycles, n + 1);
    exp = exp_q.pop_front();
    check("done_pulse", {63'd0, obs_done(sel)}, 64'd1);
    check("busy_at_done", {63'd0, obs_busy(sel)}, 64'd0);
    check("product", obs_prod(sel), exp);
    tick();
    check("done_one_cycle", {63'd0, obs_done(sel)}, 64'd0);
    check("busy_after", {63'd0, obs_busy(sel)}, 64'd0);
    check("product_stable", obs_prod(sel), exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    n_checks = 0;
    n_errors = 0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; a32 = '0; b32 = '0;
    reset = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_busy8",  {63'd0, busy8},  64'd0);
    check("rst_done8",  {63'd0, done8},  64'd0);
    check("rst_prod8",  {48'd0, prod8},  64'd0);
    check("rst_busy32", {63'd0, busy32}, 64'd0);
    check("rst_done32", {63'd0, done32}, 64'd0);
    check("rst_prod32", prod32,          64'd0);
    tick();
    tick();
    reset = 1'b0;

    // Idle with start low: everything stays zero.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_busy8",  {63'd0, busy8},  64'd0);
      check("idle_done8",  {63'd0, done8},  64'd0);
      check("idle_prod8",  {48'd0, prod8},  64'd0);
      check("idle_busy32", {63'd0, busy32}, 64'd0);
      check("idle_done32", {63'd0, done32}, 64'd0);
      check("idle_prod32", prod32,          64'd0);
    end

    // Directed N=8 cases.
    run_op(1'b0, 64'd3,   64'd5,   1'b0, 64'd0, 64'd0);
    run_op(1'b0, 64'd255, 64'd255, 1'b0, 64'd0, 64'd0);
    run_op(1'b0, 64'd0,   64'd200, 1'b0, 64'd0, 64'd0);

    // start held high through RUN and DONE: relaunches once back in IDLE.
    run_op(1'b0, 64'd7, 64'd6, 1'b1, 64'd9, 64'd9);
    run_op(1'b0, 64'd9, 64'd9, 1'b0, 64'd0, 64'd0);

    // Reset in the middle of an operation.
    drive(1'b0, 1'b1, 64'd12, 64'd12);
    tick();                                   // E0
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    for (int i = 0; i < 4; i++) tick();       // just after E4
    check("mid_busy_before", {63'd0, busy8}, 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy8}, 64'd0);
    check("mid_rst_done", {63'd0, done8}, 64'd0);
    check("mid_rst_prod", {48'd0, prod8}, 64'd0);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abandoned_no_done", {63'd0, done8}, 64'd0);
      check("abandoned_no_busy", {63'd0, busy8}, 64'd0);
    end
    run_op(1'b0, 64'd2, 64'd3, 1'b0, 64'd0, 64'd0);

    // Directed N=32 cases, including product hold during the second run.
    run_op(1'b1, 64'hFFFF_FFFF, 64'd2, 1'b0, 64'd0, 64'd0);
    run_op(1'b1, 64'd1, 64'd1, 1'b0, 64'd0, 64'd0);
    run_op(1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 64'd0, 64'd0);

    // Randomized operands with random idle gaps.
    for (int i = 0; i < 12; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      run_op(1'b0, {56'd0, 8'($urandom_range(0, 255))}, {56'd0, 8'($urandom_range(0, 255))},
             1'b0, 64'd0, 64'd0);
    end
    for (int i = 0; i < 6; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      run_op(1'b1, {32'd0, 32'($urandom)}, {32'd0, 32'($urandom)}, 1'b0, 64'd0, 64'd0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net against a hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
